// File: rtl/song_sequencer_if.sv
// song_sequencer_if
//   Bundles the song ROM read bus and the note-player bus of song_sequencer.
//   Parameters : SONG_W, IDX_W, NOTE_W, DUR_W (must match the sequencer's).
//   Signals    : rom_addr   - registered ROM address {song, note_index}
//                rom_dout   - ROM word {note, duration}, valid the cycle after
//                             rom_addr changes
//                note       - current note (0 = rest)
//                duration   - duration in beats of the current note
//                note_valid - note is sounding
//                new_note   - one-cycle pulse when note/duration load
//                song_done  - one-cycle pulse at end of song
//                busy       - sequencer is not idle
//   Modports   : master = sequencer side, slave = ROM / note player side.
interface song_sequencer_if #(
   parameter int SONG_W = 2,
   parameter int IDX_W  = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
);
   logic [SONG_W+IDX_W-1:0] rom_addr;
   logic [NOTE_W+DUR_W-1:0] rom_dout;
   logic [NOTE_W-1:0]       note;
   logic [DUR_W-1:0]        duration;
   logic                    note_valid;
   logic                    new_note;
   logic                    song_done;
   logic                    busy;

   modport master (
      output rom_addr, note, duration, note_valid, new_note, song_done, busy,
      input  rom_dout
   );

   modport slave (
      input  rom_addr, note, duration, note_valid, new_note, song_done, busy,
      output rom_dout
   );
endinterface

// File: rtl/song_sequencer.sv
// song_sequencer
//   Walks the song ROM at {song, note_index}, loads each {note, duration}
//   word and holds the note for `duration` counted beat ticks. Handles
//   play/pause, song change, end-of-song markers (duration 0) and wrap at
//   the last index of a song.
//   Ports : clk       - system clock
//           reset     - asynchronous, active-high reset
//           play      - level, 1 = playing, 0 = paused/stopped
//           song      - selected song
//           beat      - one-cycle beat tick
//           bus       - song_sequencer_if.master (ROM bus + note-player bus)
//           state_dbg - current FSM state encoding
//   Optional feature macro SONG_LOOP_EN: when defined, the end of a song
//   restarts the same song at index 0 directly from END (no IDLE visit);
//   otherwise END returns to IDLE.
//
//   Note-player protocol: there is no back-pressure. new_note pulses for
//   exactly one cycle on the cycle the new note/duration values appear;
//   note_valid is high on every cycle the note is actually sounding (PLAY
//   state with play=1) and the player must sound `note` whenever it is high.
module song_sequencer #(
   parameter int SONG_W = 2,
   parameter int IDX_W  = 5,
   parameter int NOTE_W = 6,
   parameter int DUR_W  = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               play,
   input  logic [SONG_W-1:0]  song,
   input  logic               beat,
   song_sequencer_if.master   bus,
   output logic [2:0]         state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_PLAY  = 3'd3,
      S_END   = 3'd4
   } state_t;

   state_t                  state, state_n;
   logic [IDX_W-1:0]        idx, idx_n;
   logic [SONG_W-1:0]       song_q, song_q_n;
   logic [DUR_W-1:0]        remaining, rem_n;
   logic [NOTE_W-1:0]       note_q, note_n;
   logic [DUR_W-1:0]        dur_q, dur_n;
   logic                    new_note_q, new_note_n;
   logic [SONG_W+IDX_W-1:0] rom_addr_q;
   logic [NOTE_W-1:0]       rom_note;
   logic [DUR_W-1:0]        rom_dur;
   logic                    song_chg;

   assign rom_note = bus.rom_dout[NOTE_W+DUR_W-1:DUR_W];
   assign rom_dur  = bus.rom_dout[DUR_W-1:0];
   assign song_chg = (song != song_q);

   always_comb begin
      state_n    = state;
      idx_n      = idx;
      song_q_n   = song_q;
      rem_n      = remaining;
      note_n     = note_q;
      dur_n      = dur_q;
      new_note_n = 1'b0;

      case (state)
         S_IDLE: begin
            if (play) begin
               song_q_n = song;
               idx_n    = '0;
               state_n  = S_FETCH;
            end
         end
         S_FETCH: begin
            state_n = S_WAIT;
         end
         S_WAIT: begin
            // A zero duration marks the end of the song.
            if (rom_dur == '0) begin
               state_n = S_END;
            end else begin
               note_n     = rom_note;
               dur_n      = rom_dur;
               rem_n      = rom_dur;
               new_note_n = 1'b1;
               state_n    = S_PLAY;
            end
         end
         S_PLAY: begin
            // Beats only count while playing; a paused note keeps its count.
            if (play && beat) begin
               if (remaining == DUR_W'(1)) begin
                  if (idx == '1) begin
                     state_n = S_END;
                  end else begin
                     idx_n   = idx + IDX_W'(1);
                     state_n = S_FETCH;
                  end
               end else begin
                  rem_n = remaining - DUR_W'(1);
               end
            end
         end
         S_END: begin
            idx_n = '0;
`ifdef SONG_LOOP_EN
            state_n = S_FETCH;
`else
            state_n = S_IDLE;
`endif
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // A new song selection overrides everything else outside IDLE and
      // restarts from its first entry without signalling song_done.
      if (state != S_IDLE && song_chg) begin
         state_n    = S_FETCH;
         idx_n      = '0;
         song_q_n   = song;
         rem_n      = remaining;
         note_n     = note_q;
         dur_n      = dur_q;
         new_note_n = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         idx        <= '0;
         song_q     <= '0;
         remaining  <= '0;
         note_q     <= '0;
         dur_q      <= '0;
         new_note_q <= 1'b0;
         rom_addr_q <= '0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         song_q     <= song_q_n;
         remaining  <= rem_n;
         note_q     <= note_n;
         dur_q      <= dur_n;
         new_note_q <= new_note_n;
         // The address is registered on entry to FETCH so a synchronous
         // ROM presents the word during WAIT.
         if (state_n == S_FETCH) begin
            rom_addr_q <= {song_q_n, idx_n};
         end
      end
   end

   assign bus.rom_addr   = rom_addr_q;
   assign bus.note       = note_q;
   assign bus.duration   = dur_q;
   assign bus.new_note   = new_note_q;
   assign bus.note_valid = (state == S_PLAY) && play;
   assign bus.song_done  = (state == S_END);
   assign bus.busy       = (state != S_IDLE);
   assign state_dbg      = state;

endmodule

// File: tb/tb_song_sequencer.sv
module tb_song_sequencer;

   localparam int SONG_W = 2;
   localparam int IDX_W  = 5;
   localparam int NOTE_W = 6;
   localparam int DUR_W  = 6;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_FETCH = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_PLAY  = 3'd3;

   // ---------------- clock / reset ----------------
   logic              clk;
   logic              reset;
   logic              play;
   logic [SONG_W-1:0] song;
   logic              beat;
   logic [2:0]        state_dbg;

   int checks;
   int errors;

   song_sequencer_if #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) bus ();

   song_sequencer #(.SONG_W(SONG_W), .IDX_W(IDX_W), .NOTE_W(NOTE_W), .DUR_W(DUR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .play      (play),
      .song      (song),
      .beat      (beat),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM model: word appears the cycle after the address.
   logic [NOTE_W+DUR_W-1:0] rom_mem [0:127];
   always @(posedge clk) bus.rom_dout <= rom_mem[bus.rom_addr];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- driver tasks ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat_pulse();
      beat = 1'b1;
      cyc();
      beat = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      play  = 1'b0;
      song  = '0;
      beat  = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic init_rom();
      for (int a = 0; a < 128; a++) rom_mem[a] = {6'((a % 60) + 2), 6'd1};
      rom_mem[0]  = {6'd49, 6'd12};
      rom_mem[1]  = {6'd1,  6'd8};
      rom_mem[28] = {6'd37, 6'd0};
      rom_mem[32] = {6'd10, 6'd12};
      rom_mem[96] = {6'd20, 6'd3};
   endtask

   // Runs the sequencer with a beat every other cycle until song_done or budget.
   task automatic run_song(input int budget, output int nn, output int max_addr, output bit done);
      nn = 0;
      max_addr = 0;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         beat = c[0];
         cyc();
         if (bus.new_note) nn++;
         if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
         if (bus.song_done) done = 1'b1;
      end
      beat = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1;
      play  = 1'b0;
      song  = '0;
      beat  = 1'b0;
      #1;
      checks++; if (bus.rom_addr !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got %0d want 0", bus.rom_addr); end
      checks++; if (bus.note !== 6'd0) begin errors++; $display("FAIL reset_note got %0d want 0", bus.note); end
      checks++; if (bus.duration !== 6'd0) begin errors++; $display("FAIL reset_duration got %0d want 0", bus.duration); end
      checks++; if (bus.note_valid !== 1'b0) begin errors++; $display("FAIL reset_note_valid got %b want 0", bus.note_valid); end
      checks++; if (bus.new_note !== 1'b0) begin errors++; $display("FAIL reset_new_note got %b want 0", bus.new_note); end
      checks++; if (bus.song_done !== 1'b0) begin errors++; $display("FAIL reset_song_done got %b want 0", bus.song_done); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
      checks++; if (state_dbg !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state_dbg, ST_IDLE); end
      cyc();
      cyc();
      reset = 1'b0;
      cyc();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_no_play_busy got %b want 0", bus.busy); end
   endtask

   task automatic test_basic_timing();
      do_reset();
      play = 1'b1;
      song = 2'd0;
      cyc();
      checks++; if (state_dbg !== ST_FETCH || bus.new_note !== 1'b0 || bus.busy !== 1'b1)
         begin errors++; $display("FAIL basic_cycle1 state %0d new_note %b busy %b want 1/0/1", state_dbg, bus.new_note, bus.busy); end
      checks++; if (bus.rom_addr !== 7'd0) begin errors++; $display("FAIL basic_rom_addr got %0d want 0", bus.rom_addr); end
      cyc();
      checks++; if (state_dbg !== ST_WAIT || bus.new_note !== 1'b0)
         begin errors++; $display("FAIL basic_cycle2 state %0d new_note %b want 2/0", state_dbg, bus.new_note); end
      cyc();
      checks++; if (bus.new_note !== 1'b1) begin errors++; $display("FAIL basic_new_note_latency got %b want 1", bus.new_note); end
      checks++; if (bus.note !== 6'd49 || bus.duration !== 6'd12)
         begin errors++; $display("FAIL basic_load note %0d dur %0d want 49/12", bus.note, bus.duration); end
      checks++; if (bus.note_valid !== 1'b1) begin errors++; $display("FAIL basic_note_valid got %b want 1", bus.note_valid); end
      cyc();
      checks++; if (bus.new_note !== 1'b0) begin errors++; $display("FAIL basic_new_note_width got %b want 0", bus.new_note); end
      for (int b = 1; b <= 11; b++) begin
         beat_pulse();
         checks++; if (bus.note_valid !== 1'b1 || bus.rom_addr !== 7'd0)
            begin errors++; $display("FAIL basic_hold beat %0d note_valid %b rom_addr %0d want 1/0", b, bus.note_valid, bus.rom_addr); end
      end
      beat_pulse();
      checks++; if (state_dbg !== ST_FETCH || bus.rom_addr !== 7'd1 || bus.note_valid !== 1'b0)
         begin errors++; $display("FAIL basic_note_end state %0d rom_addr %0d note_valid %b want 1/1/0", state_dbg, bus.rom_addr, bus.note_valid); end
      cyc();
      cyc();
      checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd1 || bus.duration !== 6'd8)
         begin errors++; $display("FAIL basic_second_note new_note %b note %0d dur %0d want 1/1/8", bus.new_note, bus.note, bus.duration); end
   endtask

   task automatic test_pause();
      do_reset();
      play = 1'b1;
      song = 2'd0;
      cyc(); cyc(); cyc();
      for (int b = 0; b < 5; b++) beat_pulse();
      play = 1'b0;
      cyc();
      checks++; if (bus.note_valid !== 1'b0 || state_dbg !== ST_PLAY)
         begin errors++; $display("FAIL pause_enter note_valid %b state %0d want 0/3", bus.note_valid, state_dbg); end
      for (int b = 0; b < 20; b++) begin
         beat_pulse();
         checks++; if (bus.note_valid !== 1'b0 || bus.new_note !== 1'b0 || state_dbg !== ST_PLAY)
            begin errors++; $display("FAIL pause_hold beat %0d note_valid %b new_note %b state %0d", b, bus.note_valid, bus.new_note, state_dbg); end
      end
      play = 1'b1;
      cyc();
      checks++; if (bus.note_valid !== 1'b1 || bus.new_note !== 1'b0)
         begin errors++; $display("FAIL pause_resume note_valid %b new_note %b want 1/0", bus.note_valid, bus.new_note); end
      for (int b = 1; b <= 6; b++) begin
         beat_pulse();
         checks++; if (bus.note_valid !== 1'b1 || bus.rom_addr !== 7'd0 || bus.new_note !== 1'b0)
            begin errors++; $display("FAIL pause_remaining beat %0d note_valid %b rom_addr %0d", b, bus.note_valid, bus.rom_addr); end
      end
      beat_pulse();
      checks++; if (state_dbg !== ST_FETCH || bus.rom_addr !== 7'd1)
         begin errors++; $display("FAIL pause_note_end state %0d rom_addr %0d want 1/1", state_dbg, bus.rom_addr); end
   endtask

   task automatic test_end_marker();
      int  nn;
      int  max_addr;
      bit  done;
      do_reset();
      play = 1'b1;
      song = 2'd0;
      run_song(600, nn, max_addr, done);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL end_song_done_timeout got %b want 1", done); end
      checks++; if (nn !== 28) begin errors++; $display("FAIL end_new_note_count got %0d want 28", nn); end
      checks++; if (bus.note !== 6'd29 || bus.duration !== 6'd1)
         begin errors++; $display("FAIL end_last_note note %0d dur %0d want 29/1", bus.note, bus.duration); end
      checks++; if (bus.rom_addr !== 7'd28) begin errors++; $display("FAIL end_marker_addr got %0d want 28", bus.rom_addr); end
      play = 1'b0;
      cyc();
      checks++; if (bus.song_done !== 1'b0) begin errors++; $display("FAIL end_pulse_width got %b want 0", bus.song_done); end
`ifdef SONG_LOOP_EN
      checks++; if (bus.busy !== 1'b1 || bus.rom_addr !== 7'd0)
         begin errors++; $display("FAIL end_loop_paused busy %b rom_addr %0d want 1/0", bus.busy, bus.rom_addr); end
`else
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL end_busy got %b want 0", bus.busy); end
      play = 1'b1;
      cyc();
      checks++; if (bus.rom_addr !== 7'd0 || bus.busy !== 1'b1)
         begin errors++; $display("FAIL end_next_fetch rom_addr %0d busy %b want 0/1", bus.rom_addr, bus.busy); end
`endif
   endtask

   task automatic test_full_wrap();
      int  nn;
      int  max_addr;
      bit  done;
      do_reset();
      play = 1'b1;
      song = 2'd2;
      run_song(600, nn, max_addr, done);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_song_done_timeout got %b want 1", done); end
      checks++; if (nn !== 32) begin errors++; $display("FAIL wrap_new_note_count got %0d want 32", nn); end
      checks++; if (max_addr !== 95) begin errors++; $display("FAIL wrap_max_addr got %0d want 95", max_addr); end
      checks++; if (bus.note !== 6'd37) begin errors++; $display("FAIL wrap_last_note got %0d want 37", bus.note); end
      play = 1'b0;
      cyc();
      checks++; if (bus.rom_addr === 7'd96) begin errors++; $display("FAIL wrap_addr_escape got %0d want below 96", bus.rom_addr); end
   endtask

   task automatic test_song_change_and_async_reset();
      do_reset();
      play = 1'b1;
      song = 2'd1;
      cyc(); cyc(); cyc();
      checks++; if (bus.note !== 6'd10 || bus.new_note !== 1'b1)
         begin errors++; $display("FAIL chg_first_note note %0d new_note %b want 10/1", bus.note, bus.new_note); end
      for (int b = 0; b < 3; b++) beat_pulse();
      song = 2'd3;
      cyc();
      checks++; if (bus.note_valid !== 1'b0 || state_dbg !== ST_FETCH)
         begin errors++; $display("FAIL chg_note_valid note_valid %b state %0d want 0/1", bus.note_valid, state_dbg); end
      checks++; if (bus.rom_addr !== 7'd96) begin errors++; $display("FAIL chg_rom_addr got %0d want 96", bus.rom_addr); end
      checks++; if (bus.song_done !== 1'b0) begin errors++; $display("FAIL chg_no_done_fetch got %b want 0", bus.song_done); end
      cyc();
      checks++; if (bus.song_done !== 1'b0) begin errors++; $display("FAIL chg_no_done_wait got %b want 0", bus.song_done); end
      cyc();
      checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd20 || bus.duration !== 6'd3)
         begin errors++; $display("FAIL chg_load new_note %b note %0d dur %0d want 1/20/3", bus.new_note, bus.note, bus.duration); end
      // Assert reset between edges while a note is sounding.
      #3;
      reset = 1'b1;
      #1;
      checks++; if (bus.rom_addr !== 7'd0 || bus.note !== 6'd0 || bus.duration !== 6'd0)
         begin errors++; $display("FAIL areset_data rom_addr %0d note %0d dur %0d want 0/0/0", bus.rom_addr, bus.note, bus.duration); end
      checks++; if (bus.note_valid !== 1'b0 || bus.new_note !== 1'b0 || bus.song_done !== 1'b0 || bus.busy !== 1'b0)
         begin errors++; $display("FAIL areset_flags valid %b new %b done %b busy %b want 0", bus.note_valid, bus.new_note, bus.song_done, bus.busy); end
      cyc();
      reset = 1'b0;
      play  = 1'b0;
   endtask

   task automatic test_end_restart();
      int  nn;
      int  max_addr;
      bit  done;
      do_reset();
      play = 1'b1;
      song = 2'd0;
      run_song(600, nn, max_addr, done);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL restart_done_timeout got %b want 1", done); end
      cyc();
`ifdef SONG_LOOP_EN
      checks++; if (bus.busy !== 1'b1 || state_dbg !== ST_FETCH || bus.rom_addr !== 7'd0)
         begin errors++; $display("FAIL loop_fetch busy %b state %0d rom_addr %0d want 1/1/0", bus.busy, state_dbg, bus.rom_addr); end
      cyc();
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL loop_busy got %b want 1", bus.busy); end
      cyc();
      checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd49)
         begin errors++; $display("FAIL loop_new_note new_note %b note %0d want 1/49", bus.new_note, bus.note); end
`else
      checks++; if (bus.busy !== 1'b0 || state_dbg !== ST_IDLE)
         begin errors++; $display("FAIL restart_idle busy %b state %0d want 0/0", bus.busy, state_dbg); end
      cyc();
      checks++; if (bus.rom_addr !== 7'd0 || state_dbg !== ST_FETCH)
         begin errors++; $display("FAIL restart_fetch rom_addr %0d state %0d want 0/1", bus.rom_addr, state_dbg); end
      cyc();
      cyc();
      checks++; if (bus.new_note !== 1'b1 || bus.note !== 6'd49)
         begin errors++; $display("FAIL restart_new_note new_note %b note %0d want 1/49", bus.new_note, bus.note); end
`endif
      play = 1'b0;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      checks = 0;
      errors = 0;
      init_rom();
      test_reset();
      test_basic_timing();
      test_pause();
      test_end_marker();
      test_full_wrap();
      test_song_change_and_async_reset();
      test_end_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Reader side of the song ROM interface. It walks ROM addresses {song, note_index} and fetches packed {note[5:0], duration[5:0]} words, which arrive one cycle after the address.
- Holds each note for its duration in beat ticks and presents it to the note player.
- Sits between the top-level play/song controls and the note player. It handles play/pause, song change, end-of-song markers and song wrap.

Parameters:
- SONG_W, 2, song-select width (4 songs)
- IDX_W, 5, note-index width (32 entries per song); ROM address width = SONG_W+IDX_W = 7
- NOTE_W, 6, note field width (upper bits of ROM word)
- DUR_W, 6, duration field width in beats (lower bits of ROM word)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play  in  1  level; 1 = playing, 0 = paused/stopped
- song  in  SONG_W  selected song
- beat  in  1  one-cycle beat tick (48 Hz)
- rom_addr  out  SONG_W+IDX_W  address to song ROM, registered
- rom_dout  in  NOTE_W+DUR_W  ROM data, valid the cycle after rom_addr changes
- note  out  NOTE_W  current note; 0 = rest, passed through unchanged
- duration  out  DUR_W  duration of current note
- note_valid  out  1  high while a note is sounding (PLAY state and play=1)
- new_note  out  1  one-cycle pulse when note/duration load
- song_done  out  1  one-cycle pulse at end of song
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset, asynchronous and immediate with no clock edge needed:
  - state=IDLE; idx=0; remaining=0; song_q=0.
  - All outputs 0: rom_addr, note, duration, note_valid, new_note, song_done, busy.
- Unique states: IDLE, FETCH, WAIT, PLAY, END.
- IDLE:
  - On play=1: latch song_q=song, set idx=0, go to FETCH.
- FETCH:
  - rom_addr={song_q, idx}; go to WAIT.
- WAIT (rom_dout valid this cycle):
  - If duration field is 0 (end marker), go to END.
  - Otherwise: note<=rom_dout[11:6], duration<=rom_dout[5:0], remaining<=duration, new_note=1 for one cycle, go to PLAY.
  - Latency: play rising in IDLE to new_note = 3 cycles (IDLE->FETCH->WAIT->PLAY); new_note is registered on entry to PLAY.
- PLAY:
  - beat counts only when play=1. On such a beat: remaining==1 ends the note, otherwise remaining decrements.
  - Note end with idx==all-ones: go to END.
  - Note end otherwise: idx+1, go to FETCH.
  - play=0 pauses: remaining frozen, beats ignored, note_valid=0. play=1 resumes the same note with no new_note pulse.
- END:
  - song_done=1 for one cycle; idx=0; note_valid=0; go to IDLE.
  - If play is still 1, IDLE restarts the song next cycle. Upstream drops play to stop.
- Beats arriving in IDLE/FETCH/WAIT/END are ignored; a note always lasts exactly `duration` counted beats.
- Song change: song != song_q in any non-IDLE state:
  - Next state is FETCH with idx=0 and song_q=song; note_valid=0.
  - Takes priority over note end and the end marker; no song_done pulse.
- idx never exceeds 2^IDX_W-1; rom_addr never leaves the selected song's 32-entry window.
- The width rule falls out of the widths: note occupies bits [NOTE_W+DUR_W-1:DUR_W], duration occupies [DUR_W-1:0]. Remaining is DUR_W bits.

Optional Feature:
- Macro: SONG_LOOP_EN.
- Defined: END pulses song_done, then goes directly to FETCH with idx=0 regardless of play; play=0 at that point holds in FETCH->WAIT->PLAY paused as normal. The song loops until play=0 or the song changes.
- Undefined: END returns to IDLE as specified above.

Test Plan:
- Basic note timing:
  - Stimulus: reset, play=1, song=0; ROM model entry 0={49,12}, entry 1={1,8}.
  - Required: rom_addr=0; new_note 3 cycles after play; note=49, duration=12; note_valid high across exactly 12 beats; rom_addr=1 on the cycle after the 12th beat.
- End marker:
  - Stimulus: song 0 entry 28={37,0}.
  - Required: after entry 27 completes, one song_done pulse; no new_note for entry 28; busy=0; rom_addr next fetch=0.
- Full song wrap:
  - Stimulus: song 2 with 32 nonzero durations.
  - Required: after idx 31 (rom_addr=95) completes, song_done pulses; rom_addr never reaches 96.
- Pause mid-note:
  - Stimulus: note of duration 12; play=0 after 5 beats; 20 beats while paused; then resume.
  - Required: note_valid=0 while paused; note ends after exactly 7 further beats; no extra new_note.
- Song change and async reset:
  - Song change: mid-note change song 1->3. Required: next cycle note_valid=0, then rom_addr=96 and new_note loads entry 96; no song_done.
  - Async reset: reset mid-PLAY between clock edges. Required: all outputs 0 immediately.
- SONG_LOOP_EN:
  - Stimulus: define the macro; end marker reached with play=1.
  - Required: song_done pulse, then rom_addr=base address of the song and new_note again without passing through IDLE (busy stays 1).
